// File: rtl/qam_symbol_packetizer_if.sv
// UART_PACKET stream from the QAM symbol packetizer to the UART transmitter.
// The master drives every field; the slave observes them.
interface qam_symbol_packetizer_if;
  logic [7:0] Source;
  logic [7:0] Destination;
  logic [7:0] Length;
  logic [7:0] Data;
  logic       SoP;
  logic       EoP;
  logic       Valid;

  modport master (
    output Source,
    output Destination,
    output Length,
    output Data,
    output SoP,
    output EoP,
    output Valid
  );

  modport slave (
    input Source,
    input Destination,
    input Length,
    input Data,
    input SoP,
    input EoP,
    input Valid
  );
endinterface

// File: rtl/qam_symbol_packetizer.sv
// Reassembles 4-bit QAM symbols into 16-bit words and streams them as UART packets.
// Optional idle flush of partial packets: define QAM_PKT_FLUSH_TIMEOUT_EN.
module qam_symbol_packetizer #(
  parameter int         WORDS_PER_PKT = 8,
  parameter int         FIFO_DEPTH    = 256,
  parameter logic [7:0] SRC_ADDR      = 8'h10,
  parameter logic [7:0] DEST_ADDR     = 8'h00,
  parameter int         FLUSH_CYCLES  = 4184100
) (
  input  logic                           ipClk,
  input  logic                           ipReset,
  input  logic [3:0]                     ipQAMBlock,
  input  logic                           ipQAMBlockValid,
  input  logic                           ipAlign,
  input  logic                           ipTxReady,
  qam_symbol_packetizer_if.master        opTxStream,
  output logic [12:0]                    opFIFO_Size,
  output logic                           opOverflow
);

  localparam int          AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [12:0] DEPTH = 13'(FIFO_DEPTH);
  localparam logic [12:0] WPP   = 13'(WORDS_PER_PKT);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND_LO,
    SEND_HI
  } state_t;

  // nibble assembly
  logic [1:0]  r_nib;
  logic [15:0] r_word;
  logic        r_push;
  logic [1:0]  w_nib;

  // word FIFO
  logic [15:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [12:0]   r_count;
  logic [15:0]   r_rdata;
  logic          r_ovf;
  logic          w_wr;
  logic          w_pop;

  // transmit FSM
  state_t      r_state;
  logic [12:0] r_left;
  logic        r_first;
  logic [15:0] r_txword;
  logic [7:0]  r_src;
  logic [7:0]  r_dst;
  logic [7:0]  r_len;
  logic [7:0]  r_data;
  logic        r_sop;
  logic        r_eop;
  logic        r_valid;
  logic        w_start;
  logic [12:0] w_start_words;

`ifdef QAM_PKT_FLUSH_TIMEOUT_EN
  logic [22:0] r_idle;
`else
  logic        w_unused_flush;
  assign w_unused_flush = (FLUSH_CYCLES != 0);
`endif

  // align in the same cycle as a symbol makes that symbol nibble 0
  assign w_nib = ipAlign ? 2'd0 : r_nib;

  // store each symbol into its nibble slot; request a push once nibble 3 lands
  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      r_nib  <= 2'd0;
      r_word <= 16'h0000;
      r_push <= 1'b0;
    end else begin
      r_push <= ipQAMBlockValid && (w_nib == 2'd3);
      if (ipQAMBlockValid) begin
        r_word[{w_nib, 2'b00} +: 4] <= ipQAMBlock;
        r_nib <= w_nib + 2'd1;
      end else if (ipAlign) begin
        r_nib <= 2'd0;
      end
    end
  end

  // a full FIFO still takes a word when a pop frees a slot the same cycle
  assign w_wr = r_push && ((r_count < DEPTH) || w_pop);

  // storage array; contents are don't-care once the pointers reset
  always_ff @(posedge ipClk) begin
    if (w_wr) r_mem[r_wptr] <= r_word;
  end

  // pointers, occupancy, registered read data and sticky overflow
  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= 13'd0;
      r_rdata <= 16'h0000;
      r_ovf   <= 1'b0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_pop) begin
        r_rptr  <= r_rptr + 1'b1;
        r_rdata <= r_mem[r_rptr];
      end
      unique case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 13'd1;
        2'b01:   r_count <= r_count - 13'd1;
        default: r_count <= r_count;
      endcase
      if (r_push && !w_wr) r_ovf <= 1'b1;
    end
  end

`ifdef QAM_PKT_FLUSH_TIMEOUT_EN
  // idle timer: restarts on any push and whenever a packet is in flight
  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      r_idle <= 23'd0;
    end else if (r_push || (r_state != IDLE)) begin
      r_idle <= 23'd0;
    end else if (r_idle != '1) begin
      r_idle <= r_idle + 23'd1;
    end
  end
`endif

  // packet start decision and its word count
  always_comb begin
    w_start       = 1'b0;
    w_start_words = WPP;
    if (r_state == IDLE) begin
      if (r_count >= WPP) begin
        w_start = 1'b1;
`ifdef QAM_PKT_FLUSH_TIMEOUT_EN
      end else if ((r_count != 13'd0) &&
                   (r_idle >= 23'(FLUSH_CYCLES))) begin
        w_start       = 1'b1;
        w_start_words = r_count;
`endif
      end
    end
  end

  assign w_pop = w_start ||
                 ((r_state == SEND_HI) && ipTxReady && (r_left != 13'd0));

  // transmit FSM with registered stream outputs
  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      r_state  <= IDLE;
      r_left   <= 13'd0;
      r_first  <= 1'b0;
      r_txword <= 16'h0000;
      r_src    <= 8'h00;
      r_dst    <= 8'h00;
      r_len    <= 8'h00;
      r_data   <= 8'h00;
      r_sop    <= 1'b0;
      r_eop    <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_start) begin
            r_len   <= {w_start_words[6:0], 1'b0};
            r_src   <= SRC_ADDR;
            r_dst   <= DEST_ADDR;
            r_left  <= w_start_words - 13'd1;
            r_first <= 1'b1;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          r_txword <= r_rdata;
          r_data   <= r_rdata[7:0];
          r_sop    <= r_first;
          r_eop    <= 1'b0;
          r_valid  <= 1'b1;
          r_state  <= SEND_LO;
        end
        SEND_LO: begin
          if (ipTxReady) begin
            r_data  <= r_txword[15:8];
            r_sop   <= 1'b0;
            r_first <= 1'b0;
            r_eop   <= (r_left == 13'd0);
            r_state <= SEND_HI;
          end
        end
        SEND_HI: begin
          if (ipTxReady) begin
            r_valid <= 1'b0;
            r_eop   <= 1'b0;
            if (r_left != 13'd0) begin
              r_left  <= r_left - 13'd1;
              r_state <= LOAD;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign opTxStream.Source      = r_src;
  assign opTxStream.Destination = r_dst;
  assign opTxStream.Length      = r_len;
  assign opTxStream.Data        = r_data;
  assign opTxStream.SoP         = r_sop;
  assign opTxStream.EoP         = r_eop;
  assign opTxStream.Valid       = r_valid;
  assign opFIFO_Size            = r_count;
  assign opOverflow             = r_ovf;

endmodule

// File: doc/qam_symbol_packetizer.md
Name: qam_symbol_packetizer

Overview:
- Receive-side counterpart of the modulator's UART-to-QAM streamer.
- Takes demodulated 4-bit QAM symbols and reassembles them into 16-bit words, buffering them in an internal word FIFO.
- Emits the buffered words as UART_PACKET byte streams to the UART transmitter, with back-pressure from that transmitter.
- Byte/nibble ordering mirrors the modulator: nibble 0 goes to word[3:0], and the low byte is sent before the high byte.

Parameters:
- WORDS_PER_PKT, 8, 16-bit words per transmitted packet (1..FIFO_DEPTH).
- FIFO_DEPTH, 256, word FIFO depth (power of two).
- SRC_ADDR, 8'h10, value driven on opTxStream.Source.
- DEST_ADDR, 8'h00, value driven on opTxStream.Destination.
- FLUSH_CYCLES, 4184100, idle cycles before partial flush (optional feature only).

Ports:
- ipClk  in  1  system clock; sole clock.
- ipReset  in  1  asynchronous, active-low reset; all state clears while low.
- ipQAMBlock  in  4  demodulated symbol.
- ipQAMBlockValid  in  1  symbol strobe, one cycle per symbol.
- ipAlign  in  1  pulse; discards any partial word and restarts at nibble 0.
- ipTxReady  in  1  UART transmitter accepts the current byte this cycle.
- opTxStream  out  UART_PACKET  fields driven: Source, Destination, Length, Data, SoP, EoP, Valid.
- opFIFO_Size  out  13  words currently held (0..FIFO_DEPTH).
- opOverflow  out  1  sticky; set when a completed word is dropped.

Behaviour:
- Reset (ipReset low, asynchronous):
  - opTxStream all fields 0; opFIFO_Size 0; opOverflow 0.
  - Nibble counter 0; FSM in IDLE; FIFO emptied.
- Nibble assembly:
  - 2-bit counter nib. On ipQAMBlockValid, the symbol is stored to word[4*nib+3:4*nib] and nib increments.
  - When nib=3, the word is complete and a push is issued the next cycle, so opFIFO_Size rises 1 cycle after the 4th nibble.
  - ipAlign clears nib. If ipAlign and ipQAMBlockValid occur in the same cycle, the symbol is stored as nibble 0.
- FIFO:
  - A push is accepted if count<FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the word is dropped and opOverflow is set to 1, sticky until reset.
  - Reads are registered: data is available 1 cycle after the read enable.
  - opFIFO_Size = pushes minus pops. It never wraps and never exceeds FIFO_DEPTH.
- Transmit FSM states: IDLE, LOAD, SEND_LO, SEND_HI.
  - IDLE:
    - When count>=WORDS_PER_PKT, latch pkt_words=WORDS_PER_PKT.
    - Drive Length=2*pkt_words (8-bit, truncated), Source=SRC_ADDR, Destination=DEST_ADDR.
    - Issue a FIFO read and go to LOAD.
  - LOAD: capture the read word; go to SEND_LO.
  - SEND_LO:
    - Valid=1, Data=word[7:0]; SoP=1 only for the first byte of the packet.
    - Hold all fields stable until ipTxReady=1; on acceptance go to SEND_HI.
  - SEND_HI:
    - Valid=1, Data=word[15:8]; EoP=1 only for the last word of the packet.
    - On acceptance:
      - If words remain: issue a read and go to LOAD.
      - Else: Valid=0, SoP=0, EoP=0; go to IDLE.
  - Latency: first byte Valid appears 2 cycles after IDLE observes count>=WORDS_PER_PKT.
  - Between words, Valid drops for exactly 1 cycle (the LOAD state).
  - Source, Destination and Length stay constant for the whole packet.
- Invariants:
  - Valid never deasserts while a byte is un-accepted.
  - A packet is never started unless all pkt_words are present, so there is no FIFO underflow.
- Reset mid-packet: the packet is abandoned with no EoP, and the FIFO contents are lost.

Optional Feature:
- Macro: QAM_PKT_FLUSH_TIMEOUT_EN.
- Defined:
  - A 23-bit idle counter clears on every push and on leaving IDLE.
  - In IDLE with 0<count<WORDS_PER_PKT, when the counter reaches FLUSH_CYCLES, a packet is started with pkt_words=count and Length=2*count.
- Undefined: the counter is absent, and only full packets are ever sent.

Test Plan:
- Reset, then 32 nibbles 0x0..0xF,0x0..0xF with ipTxReady=1 and WORDS_PER_PKT=8 -> one 16-byte packet. Bytes are 10,32,54,76,98,BA,DC,FE repeated; SoP on byte 0; EoP on byte 15; Length=16; Source=10; Destination=00.
- Same stimulus with ipTxReady toggling 1-of-3 cycles -> identical byte sequence. Data, SoP and EoP are held stable while Valid=1 and ipTxReady=0.
- Nibbles A,B, then ipAlign, then 1,2,3,4 -> first FIFO word is 0x4321. opFIFO_Size=1 one cycle after nibble 4.
- FIFO_DEPTH=4, WORDS_PER_PKT=8, 20 words pushed, ipTxReady=0 -> opFIFO_Size saturates at 4 and opOverflow=1. No packet is started.
- Assert ipReset low during SEND_HI of a packet -> opTxStream.Valid=0 immediately (asynchronous), opFIFO_Size=0, opOverflow=0.
- With QAM_PKT_FLUSH_TIMEOUT_EN defined, FLUSH_CYCLES=100, 3 words pushed then idle -> after 100 idle cycles a 6-byte packet is sent with Length=6. Without the macro, no packet is sent.
